// File: rtl/id_branch_redirect.sv
// Decode-stage JAL/branch redirect with 2-bit BHT prediction, ID/EX register and mispredict recovery.
// Latency: redirects are combinational (0 cycles); stall holds ID/EX, BHT and counters, and suppresses redirects.
module id_branch_redirect #(
  parameter int PC_W      = 5,
  parameter int BHT_IDX_W = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [PC_W-1:0]  id_pc,
  input  logic [PC_W-1:0]  id_pc_next,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output logic             jump,
  output logic [PC_W-1:0]  jumping,
  output logic             clr,
  output logic             ex_valid,
  output logic [31:0]      ex_instr,
  output logic [PC_W-1:0]  ex_pc,
  output logic             ex_pred_taken,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam int         BHT_N     = 2 ** BHT_IDX_W;

  // Byte immediate of a JAL or B-type instruction, sign-extended to 32 bits.
  function automatic logic [31:0] imm_of(input logic [31:0] i);
    if (i[6:0] == OP_JAL)
      imm_of = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    else
      imm_of = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [PC_W-1:0] target_of(input logic [31:0] i, input logic [PC_W-1:0] pc);
    target_of = pc + PC_W'($signed(imm_of(i)) >>> 2);
  endfunction

  logic [1:0]      bht [BHT_N];
  logic [PC_W-1:0] ex_pc_next;

  logic            id_is_jal, id_is_br, id_pred, ex_is_br;
  logic            resolve_ok, mispredict, id_redirect;
  logic [PC_W-1:0] id_target, ex_target;

  assign id_is_jal   = id_instr[6:0] == OP_JAL;
  assign id_is_br    = id_instr[6:0] == OP_BRANCH;
  assign id_pred     = id_is_br & bht[id_pc[BHT_IDX_W-1:0]][1];
  assign id_target   = target_of(id_instr, id_pc);
  assign ex_is_br    = ex_instr[6:0] == OP_BRANCH;
  assign ex_target   = target_of(ex_instr, ex_pc);

  assign resolve_ok  = ~stall & resolve_valid & ex_valid & ex_is_br;
  assign mispredict  = resolve_ok & (resolve_taken != ex_pred_taken);
  assign id_redirect = ~stall & id_valid & ~mispredict & (id_is_jal | id_pred);

  // Recovery from execute outranks a decode-side redirect.
  always_comb begin
    jump    = 1'b0;
    jumping = '0;
    if (!reset) begin
      if (mispredict) begin
        jump    = 1'b1;
        jumping = resolve_taken ? ex_target : ex_pc_next;
      end else if (id_redirect) begin
        jump    = 1'b1;
        jumping = id_target;
      end
    end
  end

  assign clr = jump;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_instr      <= '0;
      ex_pc         <= '0;
      ex_pc_next    <= '0;
      ex_pred_taken <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= id_valid & ~mispredict;
      ex_instr      <= id_instr;
      ex_pc         <= id_pc;
      ex_pc_next    <= id_pc_next;
      ex_pred_taken <= id_pred;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < BHT_N; k++) bht[k] <= 2'b01;
    end else if (resolve_ok) begin
      if (resolve_taken) begin
        if (bht[ex_pc[BHT_IDX_W-1:0]] != 2'b11)
          bht[ex_pc[BHT_IDX_W-1:0]] <= bht[ex_pc[BHT_IDX_W-1:0]] + 2'b01;
      end else begin
        if (bht[ex_pc[BHT_IDX_W-1:0]] != 2'b00)
          bht[ex_pc[BHT_IDX_W-1:0]] <= bht[ex_pc[BHT_IDX_W-1:0]] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve_ok && branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispredict && mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_branch_redirect.sv
// Directed scenarios plus a randomized run against an array-based prediction model.
module tb_id_branch_redirect;

  logic        clk = 1'b0;
  logic        reset, stall, id_valid, resolve_valid, resolve_taken;
  logic [31:0] id_instr;
  logic [4:0]  id_pc, id_pc_next;
  logic        jump, clr, ex_valid, ex_pred_taken;
  logic [4:0]  jumping, ex_pc;
  logic [31:0] ex_instr;
  logic [15:0] branch_cnt, mispred_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  id_branch_redirect dut (
    .clk(clk), .reset(reset), .stall(stall), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_next(id_pc_next), .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken), .jump(jump), .jumping(jumping), .clr(clr),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_jal(input int imm);
    logic [20:0] b;
    b = imm[20:0];
    return {b[20], b[10:1], b[11], b[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input int imm);
    logic [12:0] b;
    b = imm[12:0];
    return {b[12], b[10:5], 5'd2, 5'd1, 3'b000, b[4:1], b[11], 7'b1100011};
  endfunction

  task automatic drive(input bit st, input bit iv, input logic [31:0] ins, input int pc,
                       input bit rv, input bit rt);
    stall         = st;
    id_valid      = iv;
    id_instr      = ins;
    id_pc         = 5'(pc);
    id_pc_next    = 5'(pc + 1);
    resolve_valid = rv;
    resolve_taken = rt;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(0, 1, enc_jal(-16), 4, 0, 0);
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL reset_jump got=%0b exp=0", jump); end
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got=%0b exp=0", ex_valid); end
    tick;
    reset = 1'b0;
    drive(0, 0, NOP, 0, 0, 0);
    tick;
  endtask

  task automatic test_jal;
    drive(0, 1, enc_jal(-16), 4, 0, 0);
    checks++; if (jump !== 1'b1 || clr !== 1'b1) begin errors++; $display("FAIL jal_jump got=%0b/%0b exp=1/1", jump, clr); end
    checks++; if (jumping !== 5'd0) begin errors++; $display("FAIL jal_target got=%0d exp=0", jumping); end
    tick;
    // resolve on a non-branch in ID/EX must be ignored
    drive(0, 0, NOP, 5, 1, 1);
    checks++; if (jump !== 1'b0 || clr !== 1'b0) begin errors++; $display("FAIL jal_one_cycle got=%0b/%0b exp=0/0", jump, clr); end
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 5'd4) begin errors++; $display("FAIL jal_ex got=%0b/%0d exp=1/4", ex_valid, ex_pc); end
    tick;
    checks++; if (branch_cnt !== 16'd0) begin errors++; $display("FAIL jal_nonbranch_resolve got=%0d exp=0", branch_cnt); end
  endtask

  task automatic test_branch_mispredict;
    drive(0, 1, enc_br(8), 2, 0, 0);
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL br_weak_nt got=%0b exp=0", jump); end
    tick;
    checks++; if (ex_pred_taken !== 1'b0) begin errors++; $display("FAIL br_pred0 got=%0b exp=0", ex_pred_taken); end
    drive(0, 1, NOP, 3, 1, 1);
    checks++; if (jump !== 1'b1 || clr !== 1'b1 || jumping !== 5'd4) begin errors++; $display("FAIL br_mispredict got=%0b/%0b/%0d exp=1/1/4", jump, clr, jumping); end
    tick;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL br_kill got=%0b exp=0", ex_valid); end
    checks++; if (mispred_cnt !== 16'd1 || branch_cnt !== 16'd1) begin errors++; $display("FAIL br_cnt1 got=%0d/%0d exp=1/1", mispred_cnt, branch_cnt); end
    drive(0, 1, enc_br(8), 2, 0, 0);
    checks++; if (jump !== 1'b1 || jumping !== 5'd4) begin errors++; $display("FAIL br_pred_taken got=%0b/%0d exp=1/4", jump, jumping); end
    tick;
    checks++; if (ex_pred_taken !== 1'b1) begin errors++; $display("FAIL br_pred1 got=%0b exp=1", ex_pred_taken); end
    drive(0, 0, NOP, 0, 1, 1);
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL br_correct got=%0b exp=0", jump); end
    tick;
    checks++; if (mispred_cnt !== 16'd1 || branch_cnt !== 16'd2) begin errors++; $display("FAIL br_cnt2 got=%0d/%0d exp=1/2", mispred_cnt, branch_cnt); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, enc_br(8), 2, 0, 0);
      checks++; if (jump !== 1'b1 || jumping !== 5'd4) begin errors++; $display("FAIL sat_taken%0d got=%0b/%0d exp=1/4", i, jump, jumping); end
      tick;
      drive(0, 0, NOP, 0, 1, 1);
      checks++; if (jump !== 1'b0) begin errors++; $display("FAIL sat_resolve%0d got=%0b exp=0", i, jump); end
      tick;
    end
    drive(0, 1, enc_br(8), 2, 0, 0);
    tick;
    drive(0, 0, NOP, 0, 1, 0);
    checks++; if (jump !== 1'b1 || jumping !== 5'd3) begin errors++; $display("FAIL sat_nt_recover got=%0b/%0d exp=1/3", jump, jumping); end
    tick;
    // 11 -> 10 must still predict taken (no wrap)
    drive(0, 1, enc_br(8), 2, 0, 0);
    checks++; if (jump !== 1'b1) begin errors++; $display("FAIL sat_no_wrap got=%0b exp=1", jump); end
    tick;
    drive(0, 0, NOP, 0, 1, 0);
    tick;
    drive(0, 1, enc_br(8), 2, 0, 0);
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL sat_weak_nt got=%0b exp=0", jump); end
    tick;
    drive(0, 0, NOP, 0, 1, 0);
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL sat_nt_correct got=%0b exp=0", jump); end
    tick;
    checks++; if (branch_cnt !== 16'd8 || mispred_cnt !== 16'd3) begin errors++; $display("FAIL sat_cnt got=%0d/%0d exp=8/3", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_stall;
    logic [15:0] bc, mc;
    drive(0, 1, enc_br(8), 2, 0, 0);
    tick;
    bc = branch_cnt;
    mc = mispred_cnt;
    drive(1, 1, enc_jal(-16), 4, 1, 1);
    checks++; if (jump !== 1'b0 || clr !== 1'b0) begin errors++; $display("FAIL stall_jump got=%0b/%0b exp=0/0", jump, clr); end
    tick;
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 5'd2 || ex_instr !== enc_br(8)) begin errors++; $display("FAIL stall_hold got=%0b/%0d/%h exp=1/2/%h", ex_valid, ex_pc, ex_instr, enc_br(8)); end
    checks++; if (branch_cnt !== bc || mispred_cnt !== mc) begin errors++; $display("FAIL stall_cnt got=%0d/%0d exp=%0d/%0d", branch_cnt, mispred_cnt, bc, mc); end
    drive(0, 0, NOP, 0, 1, 1);
    checks++; if (jump !== 1'b1 || jumping !== 5'd4) begin errors++; $display("FAIL stall_release got=%0b/%0d exp=1/4", jump, jumping); end
    tick;
    // BHT[2] was 00: one taken update gives 01, still not-taken
    drive(0, 1, enc_br(8), 2, 0, 0);
    checks++; if (jump !== 1'b0) begin errors++; $display("FAIL stall_bht got=%0b exp=0", jump); end
    tick;
  endtask

  task automatic test_wrap;
    drive(0, 1, enc_br(12), 30, 0, 0);
    tick;
    drive(0, 0, NOP, 0, 1, 1);
    checks++; if (jump !== 1'b1 || jumping !== 5'd1) begin errors++; $display("FAIL wrap_recover got=%0b/%0d exp=1/1", jump, jumping); end
    tick;
    drive(0, 1, enc_br(12), 30, 0, 0);
    checks++; if (jump !== 1'b1 || jumping !== 5'd1) begin errors++; $display("FAIL wrap_pred got=%0b/%0d exp=1/1", jump, jumping); end
    tick;
  endtask

  task automatic test_mid_reset;
    drive(0, 1, enc_jal(-16), 4, 0, 0);
    reset = 1'b1;
    #1;
    checks++; if (jump !== 1'b0 || clr !== 1'b0 || jumping !== 5'd0) begin errors++; $display("FAIL mreset_jump got=%0b/%0b/%0d exp=0/0/0", jump, clr, jumping); end
    checks++; if (ex_valid !== 1'b0 || branch_cnt !== 16'd0 || mispred_cnt !== 16'd0) begin errors++; $display("FAIL mreset_state got=%0b/%0d/%0d exp=0/0/0", ex_valid, branch_cnt, mispred_cnt); end
    tick;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, enc_br(8), k, 0, 0);
      checks++; if (jump !== 1'b0) begin errors++; $display("FAIL mreset_bht%0d got=%0b exp=0", k, jump); end
      tick;
    end
    // one taken resolve from 01 must flip the prediction to taken
    drive(0, 1, enc_br(8), 5, 0, 0);
    tick;
    drive(0, 0, NOP, 0, 1, 1);
    checks++; if (jump !== 1'b1 || jumping !== 5'd7) begin errors++; $display("FAIL mreset_train got=%0b/%0d exp=1/7", jump, jumping); end
    tick;
    drive(0, 1, enc_br(8), 5, 0, 0);
    checks++; if (jump !== 1'b1) begin errors++; $display("FAIL mreset_weak got=%0b exp=1", jump); end
    tick;
  endtask

  task automatic test_random;
    int  m_bht[8];
    int  m_bcnt, m_mcnt, m_pc, m_tgt, m_pcn;
    bit  m_ev, m_isbr, m_pred;
    bit  st, iv, rv, rt, mis, e_jump, pred;
    int  kind, pc, imm, e_tgt, r, t;
    logic [31:0] ins;

    reset = 1'b1;
    drive(0, 0, NOP, 0, 0, 0);
    tick;
    reset = 1'b0;
    foreach (m_bht[k]) m_bht[k] = 1;
    m_bcnt = 0; m_mcnt = 0; m_ev = 0; m_isbr = 0; m_pred = 0; m_pc = 0; m_tgt = 0; m_pcn = 1;

    for (int c = 0; c < 400; c++) begin
      st   = ($urandom_range(0, 99) < 15);
      iv   = ($urandom_range(0, 99) < 80);
      rv   = ($urandom_range(0, 99) < 45);
      rt   = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 2));
      pc   = int'($urandom_range(0, 31));
      imm  = 0;
      if (kind == 1) begin
        r = int'($urandom_range(0, 1023));
        imm = (r - 512) * 2;
        ins = enc_jal(imm);
      end else if (kind == 2) begin
        r = int'($urandom_range(0, 4095));
        imm = (r - 2048) * 2;
        ins = enc_br(imm);
      end else begin
        ins = $urandom;
        ins[6:0] = 7'b0110011;
      end
      t    = (pc + (imm >>> 2)) & 31;
      pred = (kind == 2) && (m_bht[pc % 8] >= 2);

      mis = !st && rv && m_ev && m_isbr && (rt != m_pred);
      if (mis) begin
        e_jump = 1;
        e_tgt  = rt ? m_tgt : m_pcn;
      end else begin
        e_jump = !st && iv && ((kind == 1) || pred);
        e_tgt  = t;
      end

      drive(st, iv, ins, pc, rv, rt);
      checks++; if (jump !== e_jump || clr !== e_jump) begin errors++; $display("FAIL rnd_jump c=%0d got=%0b/%0b exp=%0b", c, jump, clr, e_jump); end
      if (e_jump) begin
        checks++; if (jumping !== 5'(e_tgt)) begin errors++; $display("FAIL rnd_target c=%0d got=%0d exp=%0d", c, jumping, e_tgt); end
      end
      tick;

      if (!st) begin
        if (rv && m_ev && m_isbr) begin
          if (rt && m_bht[m_pc % 8] < 3) m_bht[m_pc % 8]++;
          if (!rt && m_bht[m_pc % 8] > 0) m_bht[m_pc % 8]--;
          m_bcnt++;
          if (mis) m_mcnt++;
        end
        m_ev = iv && !mis; m_pc = pc; m_pcn = (pc + 1) & 31;
        m_isbr = (kind == 2); m_tgt = t; m_pred = pred;
      end

      checks++; if (ex_valid !== m_ev) begin errors++; $display("FAIL rnd_ex_valid c=%0d got=%0b exp=%0b", c, ex_valid, m_ev); end
      if (m_ev) begin
        checks++; if (ex_pc !== 5'(m_pc) || ex_pred_taken !== m_pred) begin errors++; $display("FAIL rnd_ex c=%0d got=%0d/%0b exp=%0d/%0b", c, ex_pc, ex_pred_taken, m_pc, m_pred); end
      end
      checks++; if (branch_cnt !== 16'(m_bcnt) || mispred_cnt !== 16'(m_mcnt)) begin errors++; $display("FAIL rnd_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, branch_cnt, mispred_cnt, m_bcnt, m_mcnt); end
    end
  endtask

  initial begin
    test_reset;
    test_jal;
    test_branch_mispredict;
    test_saturation;
    test_stall;
    test_wrap;
    test_mid_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
